// File: rtl/catch_judge.sv
`default_nettype none
// =============================================================================
// Module      : catch_judge
// Description : Judges catch/miss of the falling ingredient against the pot,
//               keeps score and miss count, re-arms the dropper, declares game
//               over. Optional streak scoring when COMBO_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
module catch_judge #(
    parameter int CATCH_ROW = 60,
    parameter int POT_W     = 16,
    parameter int ITEM_W    = 8,
    parameter int MAX_MISS  = 3,
    parameter int SCORE_MAX = 99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] ingr_y,
    input  logic [6:0] ingr_x,
    input  logic [6:0] pot_x,
    output logic       respawn,
    output logic       hide_ingr,
    output logic [7:0] score,
    output logic [2:0] misses,
    output logic       game_over,
    output logic [3:0] combo
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_TRACK   = 3'd1;
    localparam logic [2:0] c_CAUGHT  = 3'd2;
    localparam logic [2:0] c_MISSED  = 3'd3;
    localparam logic [2:0] c_RESPAWN = 3'd4;
    localparam logic [2:0] c_WAIT    = 3'd5;
    localparam logic [2:0] c_OVER    = 3'd6;

    localparam logic [6:0] c_Y_WAIT    = 7'd70;
    localparam logic [6:0] c_Y_LAND    = 7'd80;
    localparam logic [6:0] c_CATCH_Y   = 7'(CATCH_ROW);
    localparam logic [2:0] c_MAX_MISS  = 3'(MAX_MISS);
    localparam logic [8:0] c_SCORE_MAX = 9'(SCORE_MAX);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [6:0] r_prev_y;
    logic [7:0] r_score;
    logic [2:0] r_misses;
    logic       r_wait_seen;
    logic       r_repulsed;

    logic       w_catch_evt;
    logic       w_overlap;
    logic       w_hit;
    logic       w_landed;
    logic       w_waiting;
    logic       w_miss;
    logic       w_wait_expired;
    logic [7:0] w_item_right;
    logic [7:0] w_pot_right;
    logic [1:0] w_inc;
    logic [8:0] w_sum;
    logic [7:0] w_score_next;

    // Edge-qualified so a drop is judged only on its first sample at the row
    assign w_catch_evt  = (ingr_y == c_CATCH_Y) && (r_prev_y != c_CATCH_Y);
    assign w_item_right = {1'b0, ingr_x} + 8'(ITEM_W);
    assign w_pot_right  = {1'b0, pot_x} + 8'(POT_W);
    assign w_overlap    = (w_item_right > {1'b0, pot_x}) && ({1'b0, ingr_x} < w_pot_right);
    assign w_hit        = w_catch_evt && w_overlap;
    assign w_landed     = (ingr_y == c_Y_LAND);
    assign w_waiting    = (ingr_y == c_Y_WAIT);
    assign w_miss       = !w_catch_evt && w_landed;
    assign w_wait_expired = r_wait_seen && w_landed && !r_repulsed;

    assign w_sum        = {1'b0, r_score} + {7'd0, w_inc};
    assign w_score_next = (w_sum > c_SCORE_MAX) ? c_SCORE_MAX[7:0] : w_sum[7:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!start) begin
            w_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:    w_next = c_TRACK;
                c_TRACK: begin
                    if (w_hit) begin
                        w_next = c_CAUGHT;
                    end else if (w_miss) begin
                        w_next = c_MISSED;
                    end
                end
                c_CAUGHT: begin
                    if (w_landed) begin
                        w_next = c_RESPAWN;
                    end
                end
                c_MISSED:  w_next = (r_misses == c_MAX_MISS) ? c_OVER : c_RESPAWN;
                c_RESPAWN: w_next = c_WAIT;
                c_WAIT: begin
                    if (w_waiting) begin
                        w_next = c_TRACK;
                    end else if (w_wait_expired) begin
                        w_next = c_RESPAWN;
                    end
                end
                c_OVER:    w_next = c_OVER;
                default:   w_next = c_IDLE;
            endcase
        end
    end

    always_comb begin
        respawn   = 1'b0;
        hide_ingr = 1'b0;
        game_over = 1'b0;
        case (r_state)
            c_RESPAWN: respawn   = 1'b1;
            c_CAUGHT:  hide_ingr = 1'b1;
            c_OVER:    game_over = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_y    <= c_Y_WAIT;
            r_score     <= 8'd0;
            r_misses    <= 3'd0;
            r_wait_seen <= 1'b0;
            r_repulsed  <= 1'b0;
        end else begin
            r_prev_y <= ingr_y;
            if (start && r_state == c_IDLE) begin
                r_score  <= 8'd0;
                r_misses <= 3'd0;
            end else if (start && r_state == c_TRACK) begin
                if (w_hit) begin
                    r_score <= w_score_next;
                end else if (w_miss && r_misses != c_MAX_MISS) begin
                    r_misses <= r_misses + 3'd1;
                end
            end

            // Re-pulse allowance is granted once per drop, across WAIT/RESPAWN loops
            r_wait_seen <= (r_state == c_WAIT) && w_landed;
            if (r_state == c_WAIT) begin
                if (w_next == c_RESPAWN) begin
                    r_repulsed <= 1'b1;
                end
            end else if (r_state != c_RESPAWN) begin
                r_repulsed <= 1'b0;
            end
        end
    end

`ifdef COMBO_EN
    logic [3:0] r_combo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_combo <= 4'd0;
        end else if (start && r_state == c_IDLE) begin
            r_combo <= 4'd0;
        end else if (start && r_state == c_TRACK) begin
            if (w_hit) begin
                if (r_combo != 4'd15) begin
                    r_combo <= r_combo + 4'd1;
                end
            end else if (w_miss) begin
                r_combo <= 4'd0;
            end
        end
    end

    // Streak bonus uses the streak as it stood before this catch
    assign w_inc = (r_combo >= 4'd3) ? 2'd2 : 2'd1;
    assign combo = r_combo;
`else
    assign w_inc = 2'd1;
    assign combo = 4'd0;
`endif

    assign score  = r_score;
    assign misses = r_misses;

endmodule
`default_nettype wire
